// File: rtl/data_mem_bank.sv
`default_nettype none
// data_mem_bank: byte-addressable 32-bit data memory with a valid/ready request and
// response handshake, a fixed LAT-cycle response latency and fault reporting.
module data_mem_bank #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         WIDX_W   = ADDR_W - 2;
  localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [WIDX_W-1:0] widx;
  logic [MEM_AW-1:0] midx;
  logic [1:0]        lane;
  logic              accept;
  logic              fault;
  logic              wr_en;
  logic [3:0]        be;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;

  assign widx = req_addr[ADDR_W-1:2];
  assign midx = req_addr[MEM_AW+1:2];
  assign lane = req_addr[1:0];

  assign req_ready = (state_q == IDLE);
  // rst_n gates accept so a request held during reset never reaches the array
  assign accept    = req_valid & req_ready & rst_n;
  assign wr_en     = accept & req_write & ~fault;

  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'd0:    fault = 1'b0;
      2'd1:    fault = lane[0];
      2'd2:    fault = (lane != 2'd0);
      default: fault = 1'b1;
    endcase
    if (32'(widx) >= 32'(DEPTH)) fault = 1'b1;
  end

  // Replicate the right-aligned store data across lanes; byte enables pick the target.
  always_comb begin
    be      = 4'b0000;
    wr_word = req_wdata;
    case (req_size)
      2'd0: begin
        be      = 4'b0001 << lane;
        wr_word = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        be      = 4'b1111;
        wr_word = req_wdata;
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[midx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[midx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'h0;
    if (!req_write && !fault) begin
      case (req_size)
        2'd0:    ld_data = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
        2'd1:    ld_data = {{16{~req_unsigned & rd_half[15]}}, rd_half};
        default: ld_data = rd_word;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = ld_data;
          err_d   = fault;
          if (LAT > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bank.sv
`default_nettype none
// Testbench for data_mem_bank: a LAT=1 instance (DEPTH=64) driven from a vector
// table and a LAT=3 instance exercised with back-pressure and mid-flight reset.
module tb_data_mem_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_valid, b_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        a_ready, a_rv, a_err;
  logic [31:0] a_rdata;
  logic        b_ready, b_rv, b_err;
  logic [31:0] b_rdata;

  data_mem_bank #(.DEPTH(64), .ADDR_W(10), .LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rv),
    .rsp_ready(rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  data_mem_bank #(.DEPTH(256), .ADDR_W(10), .LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rv),
    .rsp_ready(rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                              input logic [9:0] a, input logic [31:0] d,
                              input logic [31:0] e, input logic er);
    vec_t v;
    v.w = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_err = er;
    return v;
  endfunction

  task automatic launch(input bit sel, input logic w, input logic [1:0] s, input logic u,
                        input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = d;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic xact(input bit sel, input logic w, input logic [1:0] s, input logic u,
                      input logic [9:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat);
    launch(sel, w, s, u, a, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(sel ? b_rv : a_rv) && lat < 20);
    rd  = sel ? b_rdata : a_rdata;
    err = sel ? b_err : a_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  vec_t        vt[24];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          seen;

  initial begin
    vt[0]  = mk(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 32'h00000000, 0);
    vt[1]  = mk(0, 2'd2, 1, 10'h010, 32'h0,        32'hDEADBEEF, 0);
    vt[2]  = mk(1, 2'd0, 0, 10'h013, 32'h0000007F, 32'h00000000, 0);
    vt[3]  = mk(0, 2'd2, 1, 10'h010, 32'h0,        32'h7FADBEEF, 0);
    vt[4]  = mk(0, 2'd0, 0, 10'h011, 32'h0,        32'hFFFFFFBE, 0);
    vt[5]  = mk(0, 2'd0, 1, 10'h011, 32'h0,        32'h000000BE, 0);
    vt[6]  = mk(0, 2'd1, 0, 10'h012, 32'h0,        32'h00007FAD, 0);
    vt[7]  = mk(0, 2'd1, 0, 10'h011, 32'h0,        32'h00000000, 1);
    vt[8]  = mk(0, 2'd2, 0, 10'h010, 32'h0,        32'h7FADBEEF, 0);
    vt[9]  = mk(1, 2'd2, 0, 10'h000, 32'h11223344, 32'h00000000, 0);
    vt[10] = mk(1, 2'd2, 0, 10'h100, 32'hCAFEF00D, 32'h00000000, 1);
    vt[11] = mk(0, 2'd2, 0, 10'h000, 32'h0,        32'h11223344, 0);
    vt[12] = mk(0, 2'd3, 0, 10'h000, 32'h0,        32'h00000000, 1);
    vt[13] = mk(1, 2'd1, 0, 10'h002, 32'hABCD8001, 32'h00000000, 0);
    vt[14] = mk(0, 2'd1, 0, 10'h002, 32'h0,        32'hFFFF8001, 0);
    vt[15] = mk(0, 2'd1, 1, 10'h002, 32'h0,        32'h00008001, 0);
    vt[16] = mk(0, 2'd0, 0, 10'h003, 32'h0,        32'hFFFFFF80, 0);
    vt[17] = mk(1, 2'd2, 0, 10'h002, 32'hFFFFFFFF, 32'h00000000, 1);
    vt[18] = mk(1, 2'd3, 0, 10'h000, 32'hFFFFFFFF, 32'h00000000, 1);
    vt[19] = mk(0, 2'd2, 0, 10'h000, 32'h0,        32'h80013344, 0);
    vt[20] = mk(1, 2'd0, 0, 10'h001, 32'h000001FF, 32'h00000000, 0);
    vt[21] = mk(0, 2'd2, 0, 10'h000, 32'h0,        32'h8001FF44, 0);
    vt[22] = mk(0, 2'd0, 0, 10'h000, 32'h0,        32'h00000044, 0);
    vt[23] = mk(0, 2'd2, 0, 10'h3FC, 32'h0,        32'h00000000, 1);

    // Reset with a request already presented: it must not be taken until rst_n rises.
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h3FC; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset a_rsp_valid", 32'(a_rv), 32'd0);
    chk("reset a_rdata", a_rdata, 32'h0);
    chk("reset a_err", 32'(a_err), 32'd0);
    chk("reset b_rsp_valid", 32'(b_rv), 32'd0);
    chk("reset b_rdata", b_rdata, 32'h0);
    chk("reset b_err", 32'(b_err), 32'd0);
    rst_n = 1'b1;
    chk("post-reset a_req_ready", 32'(a_ready), 32'd1);
    chk("post-reset b_req_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("first-edge accept rsp_valid", 32'(a_rv), 32'd1);
    chk("first-edge accept rsp_err", 32'(a_err), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("retired a_req_ready", 32'(a_ready), 32'd1);

    for (int i = 0; i < 24; i++) begin
      xact(1'b0, vt[i].w, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd1);
    end

    // LAT=3: store then a load held under back-pressure.
    xact(1'b1, 1'b1, 2'd2, 1'b0, 10'h040, 32'hA5A51234, rd, er, lat);
    chk("b store err", 32'(er), 32'd0);
    chk("b store latency", 32'(lat), 32'd3);

    launch(1'b1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("bp req_ready c%0d", n), 32'(b_ready), 32'd0);
      chk($sformatf("bp rsp_valid c%0d", n), 32'(b_rv), (n == 3) ? 32'd1 : 32'd0);
    end
    chk("bp rdata first", b_rdata, 32'hA5A51234);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("bp hold rsp_valid %0d", n), 32'(b_rv), 32'd1);
      chk($sformatf("bp hold req_ready %0d", n), 32'(b_ready), 32'd0);
      chk($sformatf("bp hold rdata %0d", n), b_rdata, 32'hA5A51234);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp retire req_ready", 32'(b_ready), 32'd1);
    chk("bp retire rsp_valid", 32'(b_rv), 32'd0);

    // Reset while a store sits in WAIT: response dropped, write kept.
    launch(1'b1, 1'b1, 2'd2, 1'b0, 10'h044, 32'h0F0F0F0F);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_rv) seen++;
    end
    chk("reset-in-wait store no rsp", 32'(seen), 32'd0);

    // Reset while a load sits in WAIT.
    launch(1'b1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("reset-in-wait load rsp_valid", 32'(b_rv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_rv) seen++;
    end
    chk("reset-in-wait load no rsp", 32'(seen), 32'd0);
    chk("reset-in-wait req_ready", 32'(b_ready), 32'd1);

    xact(1'b1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, rd, er, lat);
    chk("b reload rdata", rd, 32'hA5A51234);
    chk("b reload latency", 32'(lat), 32'd3);
    xact(1'b1, 1'b0, 2'd2, 1'b0, 10'h044, 32'h0, rd, er, lat);
    chk("b committed store rdata", rd, 32'h0F0F0F0F);
    chk("b committed store err", 32'(er), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
